// File: rtl/mutation_pe_if.sv
// Handshake and control bundle between the mating PE, the mutation PE and write-back.
interface mutation_pe_if #(
  parameter int WORD_SIZE   = 32,
  parameter int GENOME_SIZE = 32
);
  logic                   ctrl_load;
  logic [WORD_SIZE-1:0]   ctrl_bus;
  logic                   in_valid;
  logic                   in_ready;
  logic [GENOME_SIZE-1:0] in_genome;
  logic                   out_valid;
  logic                   out_ready;
  logic [GENOME_SIZE-1:0] out_genome;
  logic [15:0]            mut_count;

  // Upstream / downstream side driving the PE.
  modport master (
    output ctrl_load, ctrl_bus, in_valid, in_genome, out_ready,
    input  in_ready, out_valid, out_genome, mut_count
  );

  // The mutation PE itself.
  modport slave (
    input  ctrl_load, ctrl_bus, in_valid, in_genome, out_ready,
    output in_ready, out_valid, out_genome, mut_count
  );
endinterface

// File: rtl/mutation_pe.sv
// Mutation PE: captures each child genome with an LFSR sample, perturbs or
// replaces its signed link weight [7:0], and queues the result in a small
// first-word-fall-through FIFO. All-zero end markers pass through untouched
// and do not advance the LFSR, so a given genome stream mutates reproducibly.
module mutation_pe #(
  parameter int          WORD_SIZE   = 32,
  parameter int          GENOME_SIZE = 32,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic          clk,
  input logic          rst,
  mutation_pe_if.slave pe
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // 16-bit Fibonacci LFSR step, taps 15/13/12/10.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Signed 8-bit add clamped to [-128, +127].
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {a[7], a} + {b[7], b};
    if (sum[8] != sum[7]) begin
      return sum[8] ? 8'h80 : 8'h7F;
    end else begin
      return sum[7:0];
    end
  endfunction

  logic [7:0]             thr_r;
  logic [3:0]             shift_r;
  logic                   mode_r;
  logic [15:0]            lfsr_r;
  logic                   s1_valid_r;
  logic [GENOME_SIZE-1:0] s1_genome_r;
  logic [15:0]            s1_rand_r;
  logic [GENOME_SIZE-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       count_r;
  logic [15:0]            mut_count_r;

  logic                   in_ready_s;
  logic                   accept_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   mutate_s;
  logic [7:0]             delta_s;
  logic [GENOME_SIZE-1:0] result_s;
  logic [15:0]            load_seed_s;
  logic                   ctrl_unused_s;

  // Room is reserved for the genome still in stage 1, so stage 1 can always drain.
  assign in_ready_s    = rst && !pe.ctrl_load &&
                         ((count_r + CNT_W'(s1_valid_r)) < CNT_W'(FIFO_DEPTH));
  assign accept_s      = pe.in_valid && in_ready_s;
  assign push_s        = s1_valid_r;
  assign pop_s         = (count_r != CNT_W'(0)) && pe.out_ready;
  assign load_seed_s   = pe.ctrl_bus[31:16];
  assign ctrl_unused_s = ^pe.ctrl_bus[15:13];

  assign pe.in_ready   = in_ready_s;
  assign pe.out_valid  = (count_r != CNT_W'(0));
  assign pe.out_genome = fifo_mem_r[rd_ptr_r];
  assign pe.mut_count  = mut_count_r;

  // Mutation decision and rewritten weight for the genome sitting in stage 1.
  always_comb begin
    mutate_s = 1'b0;
    delta_s  = 8'h00;
    result_s = s1_genome_r;
    if (s1_genome_r != '0) begin
      mutate_s = (thr_r == 8'hFF) || (s1_rand_r[7:0] < thr_r);
    end else begin
      mutate_s = 1'b0;
    end
    delta_s = $signed(s1_rand_r[15:8]) >>> shift_r;
    if (mutate_s) begin
      if (mode_r) begin
        result_s[7:0] = s1_rand_r[15:8];
      end else begin
        result_s[7:0] = sat_add8(s1_genome_r[7:0], delta_s);
      end
    end else begin
      result_s = s1_genome_r;
    end
  end

  // Control registers and LFSR: reload on ctrl_load, step once per accepted non-marker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      thr_r   <= 8'h00;
      shift_r <= 4'h0;
      mode_r  <= 1'b0;
      lfsr_r  <= LFSR_SEED;
    end else if (pe.ctrl_load) begin
      thr_r   <= pe.ctrl_bus[7:0];
      shift_r <= pe.ctrl_bus[11:8];
      mode_r  <= pe.ctrl_bus[12];
      lfsr_r  <= (load_seed_s == 16'h0000) ? LFSR_SEED : load_seed_s;
    end else if (accept_s && (pe.in_genome != '0)) begin
      lfsr_r  <= lfsr_next(lfsr_r);
    end else begin
      lfsr_r  <= lfsr_r;
    end
  end

  // Stage 1: hold the accepted genome with the LFSR value it will be mutated by.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_r  <= 1'b0;
      s1_genome_r <= '0;
      s1_rand_r   <= 16'h0000;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_genome_r <= pe.in_genome;
        s1_rand_r   <= lfsr_r;
      end else begin
        s1_genome_r <= s1_genome_r;
      end
    end
  end

  // Output FIFO: stage-1 result pushed at the tail, head popped by the consumer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= result_s;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Saturating count of genomes whose weight was actually mutated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mut_count_r <= 16'h0000;
    end else if (push_s && mutate_s && (mut_count_r != 16'hFFFF)) begin
      mut_count_r <= mut_count_r + 16'h0001;
    end else begin
      mut_count_r <= mut_count_r;
    end
  end

endmodule

// File: tb/tb_mutation_pe.sv
// Directed bench for mutation_pe: hand-computed vectors plus a reference
// model of the LFSR/mutation rules that scores every FIFO output in order.
module tb_mutation_pe;

  logic clk;
  logic rst;
  int   tests_run = 0;
  int   failed    = 0;

  mutation_pe_if ifc ();

  mutation_pe dut (
    .clk (clk),
    .rst (rst),
    .pe  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [7:0]  t_thr;
  logic [3:0]  t_shift;
  logic        t_mode;
  logic [15:0] t_lfsr;
  logic [15:0] t_mut;
  logic [31:0] last_out;
  logic [31:0] offer_q[$];
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cw(input logic [15:0] seed, input logic mode,
                                     input logic [3:0] shift, input logic [7:0] thr);
    return {seed, 3'b000, mode, shift, thr};
  endfunction

  function automatic logic [15:0] ref_lfsr(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return {l[14:0], fb};
  endfunction

  function automatic logic [32:0] ref_mut(input logic [31:0] g, input logic [15:0] r);
    logic        mut;
    logic [31:0] o;
    int          w, d, s;
    o   = g;
    mut = (g != 32'h0) && ((t_thr == 8'hFF) || (r[7:0] < t_thr));
    if (mut) begin
      if (t_mode) begin
        o[7:0] = r[15:8];
      end else begin
        w = $signed(g[7:0]);
        d = $signed(r[15:8]);
        d = d >>> t_shift;
        s = w + d;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        o[7:0] = s[7:0];
      end
    end
    return {mut, o};
  endfunction

  task automatic model_reset();
    t_thr = 8'h00; t_shift = 4'h0; t_mode = 1'b0; t_lfsr = 16'hACE1; t_mut = 16'h0000;
    offer_q.delete(); exp_q.delete();
  endtask

  task automatic kick();
    ifc.in_valid  = (offer_q.size() != 0);
    ifc.in_genome = (offer_q.size() != 0) ? offer_q[0] : 32'h0;
  endtask

  // One clock: observe at the falling edge, model what the rising edge will do.
  task automatic step_cycle();
    logic [32:0] res;
    logic [31:0] g;
    @(negedge clk);
    if (ifc.ctrl_load) begin
      check("load_cycle_in_ready", {31'b0, ifc.in_ready}, 32'h0);
      t_thr   = ifc.ctrl_bus[7:0];
      t_shift = ifc.ctrl_bus[11:8];
      t_mode  = ifc.ctrl_bus[12];
      t_lfsr  = (ifc.ctrl_bus[31:16] == 16'h0) ? 16'hACE1 : ifc.ctrl_bus[31:16];
    end
    if (ifc.out_valid && ifc.out_ready) begin
      check("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        last_out = ifc.out_genome;
        check("out_data", ifc.out_genome, exp_q.pop_front());
      end
    end
    if (ifc.in_valid && ifc.in_ready && offer_q.size() != 0) begin
      g   = offer_q.pop_front();
      res = ref_mut(g, t_lfsr);
      if (g != 32'h0) t_lfsr = ref_lfsr(t_lfsr);
      if (res[32] && t_mut != 16'hFFFF) t_mut = t_mut + 16'h0001;
      exp_q.push_back(res[31:0]);
    end
    @(posedge clk);
    #1;
    kick();
  endtask

  task automatic load(input logic [31:0] w);
    ifc.ctrl_load = 1'b1;
    ifc.ctrl_bus  = w;
    step_cycle();
    ifc.ctrl_load = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    ifc.out_ready = 1'b1;
    while ((offer_q.size() != 0 || exp_q.size() != 0) && n < limit) begin
      step_cycle();
      n++;
    end
    check("drain_done", 32'(offer_q.size() + exp_q.size()), 32'd0);
    offer_q.delete(); exp_q.delete();
    kick();
  endtask

  task automatic send_one(input logic [31:0] g);
    last_out = 32'hDEADBEEF;
    offer_q.push_back(g);
    kick();
    drain(50);
  endtask

  initial begin
    rst = 1'b0;
    ifc.ctrl_load = 1'b0; ifc.ctrl_bus = 32'h0; ifc.in_valid = 1'b1;
    ifc.in_genome = 32'h12345678; ifc.out_ready = 1'b0;
    model_reset();
    last_out = 32'h0;
    @(posedge clk); #1;
    // reset state
    check("rst_in_ready", {31'b0, ifc.in_ready}, 32'h0);
    check("rst_out_valid", {31'b0, ifc.out_valid}, 32'h0);
    check("rst_out_genome", ifc.out_genome, 32'h0);
    check("rst_mut_count", {16'h0, ifc.mut_count}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    kick();

    // T2: replace mode, latency and count
    load(cw(16'h1234, 1'b1, 4'h0, 8'hFF));
    ifc.out_ready = 1'b0;
    offer_q.push_back(32'h5A030210);
    kick();
    step_cycle();
    check("t2_accepted", 32'(exp_q.size()), 32'd1);
    check("t2_valid_after_n", {31'b0, ifc.out_valid}, 32'h0);
    step_cycle();
    check("t2_valid_after_n1", {31'b0, ifc.out_valid}, 32'h1);
    check("t2_out_hand", ifc.out_genome, 32'h5A030212);
    drain(20);
    check("t2_mut_count", {16'h0, ifc.mut_count}, 32'd1);

    // T3: perturb with saturation, shift, and threshold boundary
    load(cw(16'h1234, 1'b0, 4'h0, 8'hFF));
    send_one(32'h0102037F);
    check("t3_sat_pos", last_out, 32'h0102037F);
    load(cw(16'hF000, 1'b0, 4'h0, 8'hFF));
    send_one(32'h01020380);
    check("t3_sat_neg", last_out, 32'h01020380);
    load(cw(16'hF000, 1'b0, 4'h2, 8'hFF));
    send_one(32'h0A0B0C10);
    check("t3_shift2", last_out, 32'h0A0B0C0C);
    load(cw(16'h12FF, 1'b1, 4'h0, 8'h80));
    send_one(32'h11223344);
    check("t3_thr_miss", last_out, 32'h11223344);
    load(cw(16'h4501, 1'b1, 4'h0, 8'h02));
    send_one(32'h11223344);
    check("t3_thr_hit", last_out, 32'h11223345);
    check("t3_mut_count", {16'h0, ifc.mut_count}, 32'd5);

    // end marker does not step the LFSR; zero seed falls back to LFSR_SEED
    load(cw(16'h4321, 1'b1, 4'h0, 8'hFF));
    send_one(32'h00000000);
    check("marker_pass", last_out, 32'h00000000);
    send_one(32'h00000001);
    check("marker_no_step", last_out, 32'h00000043);
    load(cw(16'h0000, 1'b1, 4'h0, 8'hFF));
    send_one(32'h00000055);
    check("seed0_first", last_out, 32'h000000AC);
    send_one(32'h00000066);
    check("seed0_second", last_out, 32'h00000059);
    check("marker_mut_count", {16'h0, ifc.mut_count}, 32'd8);

    // T4: threshold 0 bypasses 100 random genomes
    load(cw(16'h1111, 1'b0, 4'h0, 8'h00));
    for (int i = 0; i < 100; i++) offer_q.push_back($urandom());
    kick();
    drain(400);
    check("t4_mut_count", {16'h0, ifc.mut_count}, 32'd8);

    // T5: backpressure, then continuous streaming with push+pop cycles
    load(cw(16'h7777, 1'b1, 4'h0, 8'hFF));
    ifc.out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) offer_q.push_back(32'h10000000 + 32'(i));
    kick();
    for (int i = 0; i < 10; i++) begin
      step_cycle();
      if (i >= 6) check("t5_head_stable", ifc.out_genome, exp_q[0]);
    end
    check("t5_stored", 32'(exp_q.size()), 32'd4);
    check("t5_left", 32'(offer_q.size()), 32'd2);
    check("t5_in_ready_low", {31'b0, ifc.in_ready}, 32'h0);
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step_cycle();
    check("t5_stream_6_cycles", 32'(exp_q.size() + offer_q.size()), 32'd0);
    drain(20);
    check("t5_mut_count", {16'h0, ifc.mut_count}, {16'h0, t_mut});

    // T6: ctrl_load in the middle of a stream
    load(cw(16'hBEEF, 1'b0, 4'h3, 8'hA0));
    for (int i = 0; i < 8; i++) offer_q.push_back(32'hC0DE0000 + 32'(i * 37));
    ifc.out_ready = 1'b1;
    kick();
    for (int i = 0; i < 3; i++) step_cycle();
    load(cw(16'h5555, 1'b1, 4'h0, 8'hC0));
    drain(60);
    check("t6_mut_count", {16'h0, ifc.mut_count}, {16'h0, t_mut});

    // T1: asynchronous reset with three genomes buffered
    load(cw(16'h2222, 1'b1, 4'h0, 8'hFF));
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) offer_q.push_back(32'hAB000001 + 32'(i));
    kick();
    for (int i = 0; i < 5; i++) step_cycle();
    check("t1_pre_valid", {31'b0, ifc.out_valid}, 32'h1);
    #3;
    rst = 1'b0;
    ifc.in_valid = 1'b1;
    #1;
    check("t1_out_valid", {31'b0, ifc.out_valid}, 32'h0);
    check("t1_mut_count", {16'h0, ifc.mut_count}, 32'h0);
    check("t1_in_ready", {31'b0, ifc.in_ready}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    kick();
    step_cycle();
    step_cycle();
    check("t1_fifo_empty", {31'b0, ifc.out_valid}, 32'h0);
    send_one(32'h11223344);
    check("t1_ctrl_cleared", last_out, 32'h11223344);
    check("t1_count_after", {16'h0, ifc.mut_count}, 32'h0);
    load(cw(16'h0000, 1'b1, 4'h0, 8'hFF));
    send_one(32'h00000055);
    check("t1_fresh_run", last_out, 32'h000000AC);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
